// File: rtl/stream_mux_arb_if.sv
// Handshake bundle for the N-channel stream multiplexer.
// Producers and consumer sit on the master side, the mux on the slave side.
interface stream_mux_arb_if #(
    parameter int NR_CH      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_W      = 2
);
    logic                        mode;
    logic [SEL_W-1:0]            sel;
    logic [NR_CH-1:0]            in_valid;
    logic [NR_CH*DATA_WIDTH-1:0] in_data;
    logic [NR_CH-1:0]            in_ready;
    logic                        out_valid;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]            out_ch;
    logic                        out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel stream mux with registered output stage.
// Grant is either the explicit sel channel or round-robin after rr_ptr.
module stream_mux_arb #(
    parameter int NR_CH      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_W      = 2
) (
    input logic             clk,
    input logic             rst,
    stream_mux_arb_if.slave bus
);
    localparam int PW = SEL_W + 1;
    localparam logic [PW-1:0] NCH = PW'(NR_CH);

    logic [NR_CH-1:0]      grant;
    logic [NR_CH-1:0]      ready;
    logic [SEL_W-1:0]      gnt_id;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0]      rr_ptr;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SEL_W-1:0]      ch_q;
    logic                  slot_free;
    logic                  xfer;
    logic                  found;
    logic [PW-1:0]         idx;

    // Pick at most one channel: explicit sel, or first valid after rr_ptr.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (bus.mode) begin
            for (int i = 1; i <= NR_CH; i++) begin
                idx = {1'b0, rr_ptr} + PW'(i);
                if (idx >= NCH)
                    idx = idx - NCH;
                for (int k = 0; k < NR_CH; k++) begin
                    if (!found && idx == PW'(k) && bus.in_valid[k]) begin
                        grant[k] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end else begin
            for (int k = 0; k < NR_CH; k++) begin
                if (bus.sel == SEL_W'(k) && bus.in_valid[k])
                    grant[k] = 1'b1;
            end
        end
    end

    // Encode the granted channel id and select its payload.
    always_comb begin
        gnt_id   = '0;
        gnt_data = '0;
        for (int k = 0; k < NR_CH; k++) begin
            if (grant[k]) begin
                gnt_id   = SEL_W'(k);
                gnt_data = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Accept only when the output slot is empty or draining this cycle.
    always_comb begin
        slot_free = !valid_q || bus.out_ready;
        ready     = (rst || !slot_free) ? '0 : grant;
        xfer      = |ready;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            rr_ptr  <= SEL_W'(NR_CH - 1);
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= gnt_data;
            ch_q    <= gnt_id;
            rr_ptr  <= gnt_id;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed + random bench for stream_mux_arb (NR_CH=3).
// A transaction-level model predicts ready, output word and channel.
module tb_stream_mux_arb;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_ptr;
    logic [N-1:0]  exp_rdy;

    stream_mux_arb_if #(.NR_CH(N), .DATA_WIDTH(DW), .SEL_W(SW)) bus ();

    stream_mux_arb #(.NR_CH(N), .DATA_WIDTH(DW), .SEL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setd(input int c, input logic [DW-1:0] v);
        bus.in_data[c*DW +: DW] = v;
    endtask

    task automatic set_in(input logic md, input logic [SW-1:0] s,
                          input logic [N-1:0] v, input logic r);
        bus.mode      = md;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = r;
    endtask

    // One cycle: predict and check ready mid-cycle, advance model at the
    // edge, then check the registered outputs just after it.
    task automatic step();
        int g;
        int s;
        int c;
        @(negedge clk);
        g = -1;
        if (!bus.mode) begin
            s = int'(bus.sel);
            if (s < N) begin
                if (bus.in_valid[s])
                    g = s;
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                c = (m_ptr + i) % N;
                if (g < 0 && bus.in_valid[c])
                    g = c;
            end
        end
        exp_rdy = '0;
        if (!rst && (!m_valid || bus.out_ready) && g >= 0)
            exp_rdy[g] = 1'b1;
        chk("in_ready", DW'(bus.in_ready), DW'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = N - 1;
        end else if (exp_rdy != '0) begin
            m_valid = 1'b1;
            m_data  = bus.in_data[g*DW +: DW];
            m_ch    = g;
            m_ptr   = g;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", DW'(bus.out_valid), DW'(m_valid));
        chk("out_data", bus.out_data, m_data);
        chk("out_ch", DW'(bus.out_ch), DW'(m_ch));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = N - 1;
        rst     = 1'b1;
        bus.in_data = '0;
        set_in(1'b0, 2'd0, 3'b000, 1'b0);
        step();
        step();

        // Round-robin with all channels valid: 0,1,2,0,1,2.
        rst = 1'b0;
        set_in(1'b1, 2'd0, 3'b111, 1'b1);
        setd(0, 32'hA0); setd(1, 32'hA1); setd(2, 32'hA2);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_seq", DW'(bus.out_ch), DW'(i % N));
        end

        // Explicit select waits for its own channel.
        set_in(1'b0, 2'd2, 3'b011, 1'b1);
        setd(2, 32'hDEADBEEF);
        step();
        step();
        chk("sel2_idle", DW'(bus.out_valid), 32'd0);
        bus.in_valid = 3'b111;
        step();
        chk("sel2_data", bus.out_data, 32'hDEADBEEF);
        chk("sel2_ch", DW'(bus.out_ch), 32'd2);

        // Out-of-range select never grants.
        set_in(1'b0, 2'd3, 3'b111, 1'b1);
        for (int i = 0; i < 3; i++)
            step();
        chk("sel3_idle", DW'(bus.out_valid), 32'd0);

        // Backpressure holds the word and blocks inputs.
        set_in(1'b0, 2'd0, 3'b001, 1'b1);
        setd(0, 32'h11);
        step();
        bus.out_ready = 1'b0;
        setd(0, 32'h22);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold", bus.out_data, 32'h11);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_load", bus.out_data, 32'h22);

        // Reset while stalled, then rr restarts after ch2.
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_valid", DW'(bus.out_valid), 32'd0);
        rst = 1'b0;
        set_in(1'b1, 2'd0, 3'b110, 1'b1);
        step();
        chk("rst_ptr", DW'(bus.out_ch), 32'd1);

        // Wrap-around after repeated ch2 grants.
        bus.in_valid = 3'b100;
        step();
        step();
        bus.in_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap_seq", DW'(bus.out_ch), DW'(i));
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++)
                setd(c, $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
